pes_elevator_call_sched: RTL and testbench

//  Upstream request stage for pes_elevator. Collects car/hall call presses into a

---
 rtl/pes_elevator_call_sched.sv | 222 ++++++++++++++++++++++
 tb/tb_pes_elevator_call_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pes_elevator_call_sched.sv
`default_nettype none
// ============================================================================
//  Module   : pes_elevator_call_sched
//  Purpose  : Call collection and SCAN-ordered target selection for the
//             pes_elevator car. Presses are held in a sticky pending set. The
//             next one-hot target goes out on request_floor/req_valid, and the
//             call is retired when the car reports done at that floor.
//  Option   : define ELEV_REQ_TIMEOUT_EN to enable the WAIT_DONE watchdog
//             (sticky stall output); otherwise stall is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module pes_elevator_call_sched #(
  parameter int N_FLOORS       = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TMR_W          = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] call_btn,
  input  logic [N_FLOORS-1:0] cur_floor,
  input  logic                done,
  output logic [N_FLOORS-1:0] request_floor,
  output logic                req_valid,
  output logic [N_FLOORS-1:0] pending,
  output logic                sweep_up,
  output logic                busy,
  output logic                stall
);

  localparam int IDX_W = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1;
  localparam logic [N_FLOORS-1:0] ONE_VEC = {{(N_FLOORS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_CLEAR     = 2'd3
  } state_t;

  // Reject a watchdog counter too narrow to reach its limit.
  if (TMR_W < 1 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TMR_W)) begin : g_bad_cfg
    $error("pes_elevator_call_sched: TMR_W cannot hold TIMEOUT_CYCLES");
  end

  state_t              state_q, state_d;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  logic [N_FLOORS-1:0] request_floor_q, request_floor_d;
  logic                req_valid_q, req_valid_d;
  logic                sweep_up_q, sweep_up_d;

`ifdef ELEV_REQ_TIMEOUT_EN
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                stall_q, stall_d;
`endif

  logic                cur_valid;
  logic [IDX_W-1:0]    cur_idx;
  logic                hit_ge, hit_lt, hit_le, hit_gt;
  logic [IDX_W-1:0]    idx_ge, idx_lt, idx_le, idx_gt;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_flip;
  logic [N_FLOORS-1:0] sel_onehot;
  logic                issue_ok;

  // Decode the car position; zero or multi-hot positions are treated as unknown.
  always_comb begin
    cur_valid = (cur_floor != '0) && ((cur_floor & (cur_floor - ONE_VEC)) == '0);
    cur_idx   = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (cur_floor[i]) cur_idx = IDX_W'(i);
    end
  end

  // Scan the pending set on both sides of the car for the SCAN candidates.
  always_comb begin
    hit_ge = 1'b0; idx_ge = '0;   // lowest  index >= car
    hit_lt = 1'b0; idx_lt = '0;   // highest index <  car
    hit_le = 1'b0; idx_le = '0;   // highest index <= car
    hit_gt = 1'b0; idx_gt = '0;   // lowest  index >  car
    // Descending walk: the last match seen is the lowest index.
    for (int i = N_FLOORS - 1; i >= 0; i--) begin
      if (pending_q[i] && (IDX_W'(i) >= cur_idx)) begin
        hit_ge = 1'b1;
        idx_ge = IDX_W'(i);
      end
      if (pending_q[i] && (IDX_W'(i) > cur_idx)) begin
        hit_gt = 1'b1;
        idx_gt = IDX_W'(i);
      end
    end
    // Ascending walk: the last match seen is the highest index.
    for (int i = 0; i < N_FLOORS; i++) begin
      if (pending_q[i] && (IDX_W'(i) < cur_idx)) begin
        hit_lt = 1'b1;
        idx_lt = IDX_W'(i);
      end
      if (pending_q[i] && (IDX_W'(i) <= cur_idx)) begin
        hit_le = 1'b1;
        idx_le = IDX_W'(i);
      end
    end
  end

  // Pick the target: continue the sweep if possible, otherwise reverse.
  always_comb begin
    sel_idx  = '0;
    sel_flip = 1'b0;
    if (sweep_up_q) begin
      if (hit_ge) begin
        sel_idx = idx_ge;
      end else begin
        sel_idx  = idx_lt;
        sel_flip = hit_lt;
      end
    end else begin
      if (hit_le) begin
        sel_idx = idx_le;
      end else begin
        sel_idx  = idx_gt;
        sel_flip = hit_gt;
      end
    end
    sel_onehot          = '0;
    sel_onehot[sel_idx] = 1'b1;
  end

  // A stalled watchdog blocks further issues until reset.
`ifdef ELEV_REQ_TIMEOUT_EN
  assign issue_ok = (pending_q != '0) && cur_valid && !stall_q;
`else
  assign issue_ok = (pending_q != '0) && cur_valid;
`endif

  // Next-state computation for the FSM, pending set and registered outputs.
  always_comb begin
    state_d         = state_q;
    pending_d       = pending_q | call_btn;
    request_floor_d = request_floor_q;
    req_valid_d     = req_valid_q;
    sweep_up_d      = sweep_up_q;
`ifdef ELEV_REQ_TIMEOUT_EN
    tmr_d           = tmr_q;
    stall_d         = stall_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (issue_ok) begin
          request_floor_d = sel_onehot;
          req_valid_d     = 1'b1;
          if (sel_flip) sweep_up_d = !sweep_up_q;
          state_d         = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_DONE;
`ifdef ELEV_REQ_TIMEOUT_EN
        tmr_d   = '0;
`endif
      end
      ST_WAIT_DONE: begin
        // Only completion at the issued floor retires the call.
        if (done && (cur_floor == request_floor_q)) begin
          state_d = ST_CLEAR;
`ifdef ELEV_REQ_TIMEOUT_EN
        end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          // Give up on this target but keep the call pending.
          stall_d     = 1'b1;
          req_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
`endif
        end
      end
      ST_CLEAR: begin
        // Retiring the served floor overrides a same-cycle press of it.
        pending_d   = (pending_q | call_btn) & ~request_floor_q;
        req_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      pending_q       <= '0;
      request_floor_q <= '0;
      req_valid_q     <= 1'b0;
      sweep_up_q      <= 1'b1;
`ifdef ELEV_REQ_TIMEOUT_EN
      tmr_q           <= '0;
      stall_q         <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      request_floor_q <= request_floor_d;
      req_valid_q     <= req_valid_d;
      sweep_up_q      <= sweep_up_d;
`ifdef ELEV_REQ_TIMEOUT_EN
      tmr_q           <= tmr_d;
      stall_q         <= stall_d;
`endif
    end
  end

  assign request_floor = request_floor_q;
  assign req_valid     = req_valid_q;
  assign pending       = pending_q;
  assign sweep_up      = sweep_up_q;
  assign busy          = (state_q != ST_IDLE);
`ifdef ELEV_REQ_TIMEOUT_EN
  assign stall         = stall_q;
`else
  assign stall         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pes_elevator_call_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pes_elevator_call_sched
//  Purpose  : Self-checking bench for pes_elevator_call_sched. Expected
//             {sweep_up, request_floor} pairs are queued as calls are driven
//             and compared whenever req_valid rises.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pes_elevator_call_sched;

  localparam int NF = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [NF-1:0] call_btn;
  logic [NF-1:0] cur_floor;
  logic          done;
  logic [NF-1:0] request_floor;
  logic          req_valid;
  logic [NF-1:0] pending;
  logic          sweep_up;
  logic          busy;
  logic          stall;

  int n_chk  = 0;
  int n_pass = 0;

  logic [NF:0] exp_q[$];   // {sweep_up, request_floor}
  logic        rv_prev = 1'b0;

  pes_elevator_call_sched #(
    .N_FLOORS      (NF),
    .TIMEOUT_CYCLES(TO),
    .TMR_W         (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .call_btn     (call_btn),
    .cur_floor    (cur_floor),
    .done         (done),
    .request_floor(request_floor),
    .req_valid    (req_valid),
    .pending      (pending),
    .sweep_up     (sweep_up),
    .busy         (busy),
    .stall        (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each new issue is matched against the oldest expectation.
  always @(negedge clk) begin
    if (req_valid && !rv_prev) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_issue", {23'd0, sweep_up, request_floor}, 32'h0);
      end else begin
        logic [NF:0] e;
        e = exp_q.pop_front();
        chk("sb_target", {24'd0, request_floor}, {24'd0, e[NF-1:0]});
        chk("sb_sweep", {31'd0, sweep_up}, {31'd0, e[NF]});
      end
    end
    rv_prev = req_valid;
  end

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    tick();
  endtask

  task automatic press(input logic [NF-1:0] f);
    call_btn = f;
    tick();
    call_btn = '0;
  endtask

  task automatic wait_issue(input string tag);
    int n;
    n = 0;
    while (!req_valid && n < 20) begin
      tick();
      n++;
    end
    if (!req_valid) chk(tag, 32'd0, 32'd1);
  endtask

  // Move from ISSUE into WAIT_DONE, complete at the target, check retirement.
  task automatic serve(input logic [NF-1:0] f, input string tag);
    tick();
    cur_floor = f;
    done      = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk({tag, "_bit_cleared"}, {31'd0, |(pending & f)}, 32'd0);
    chk({tag, "_rv_low"}, {31'd0, req_valid}, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    call_btn  = '0;
    cur_floor = '0;
    done      = 1'b0;
    #2;
    chk("rst_pending", {24'd0, pending}, 32'h0);
    chk("rst_request", {24'd0, request_floor}, 32'h0);
    chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
    chk("rst_sweep_up", {31'd0, sweep_up}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    #10;
    reset = 1'b0;
    tick();

    // Invalid car position: nothing is issued.
    cur_floor = 8'h06;
    press(8'h08);
    tick(); tick();
    chk("multihot_no_issue", {31'd0, req_valid}, 32'd0);
    chk("multihot_idle", {31'd0, busy}, 32'd0);
    do_reset();

    // Single call from floor 0 to floor 4, exact two-edge latency.
    cur_floor = 8'h01;
    exp_q.push_back({1'b1, 8'h10});
    press(8'h10);
    chk("t1_pending_set", {24'd0, pending}, 32'h10);
    chk("t1_not_yet", {31'd0, req_valid}, 32'd0);
    tick();
    chk("t1_req", {24'd0, request_floor}, 32'h10);
    chk("t1_req_valid", {31'd0, req_valid}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    serve(8'h10, "t1");
    chk("t1_pending_empty", {24'd0, pending}, 32'h0);
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // SCAN order from floor 3 with floors 1,5,7 pending.
    do_reset();
    cur_floor = 8'h08;
    exp_q.push_back({1'b1, 8'h20});
    exp_q.push_back({1'b1, 8'h80});
    exp_q.push_back({1'b0, 8'h02});
    press(8'hA2);
    wait_issue("t2_issue0_timeout");
    chk("t2_pending", {24'd0, pending}, 32'hA2);
    serve(8'h20, "t2a");
    wait_issue("t2_issue1_timeout");
    serve(8'h80, "t2b");
    wait_issue("t2_issue2_timeout");
    chk("t2_sweep_down", {31'd0, sweep_up}, 32'd0);
    serve(8'h02, "t2c");
    chk("t2_pending_empty", {24'd0, pending}, 32'h0);

    // Completion at the wrong floor is ignored; a later press is served next.
    do_reset();
    cur_floor = 8'h08;
    exp_q.push_back({1'b1, 8'h20});
    press(8'h20);
    wait_issue("t3_issue0_timeout");
    tick();
    done = 1'b1;
    tick(); tick();
    done = 1'b0;
    chk("t3_wrong_done_rv", {31'd0, req_valid}, 32'd1);
    chk("t3_wrong_done_req", {24'd0, request_floor}, 32'h20);
    press(8'h04);
    chk("t3_bit2_set", {24'd0, pending}, 32'h24);
    exp_q.push_back({1'b0, 8'h04});
    // Already in WAIT_DONE: complete directly.
    cur_floor = 8'h20;
    done      = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk("t3_bit5_cleared", {24'd0, pending}, 32'h04);
    wait_issue("t3_issue1_timeout");
    serve(8'h04, "t3b");

    // Same-cycle press during CLEAR loses to the clear.
    do_reset();
    cur_floor = 8'h01;
    exp_q.push_back({1'b1, 8'h10});
    press(8'h10);
    wait_issue("t4_issue0_timeout");
    tick();
    cur_floor = 8'h10;
    done      = 1'b1;
    tick();
    done     = 1'b0;
    call_btn = 8'h10;
    tick();
    call_btn = '0;
    chk("t4_clear_wins", {24'd0, pending}, 32'h0);
    tick();
    chk("t4_no_reissue", {31'd0, req_valid}, 32'd0);

    // Asynchronous reset while waiting for completion.
    exp_q.push_back({1'b1, 8'h40});
    press(8'h40);
    wait_issue("t4_issue1_timeout");
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("t4_arst_pending", {24'd0, pending}, 32'h0);
    chk("t4_arst_request", {24'd0, request_floor}, 32'h0);
    chk("t4_arst_rv", {31'd0, req_valid}, 32'd0);
    chk("t4_arst_sweep", {31'd0, sweep_up}, 32'd1);
    chk("t4_arst_busy", {31'd0, busy}, 32'd0);
    #10;
    reset = 1'b0;
    tick();

    // Completion never arrives.
    cur_floor = 8'h01;
    exp_q.push_back({1'b1, 8'h08});
    press(8'h08);
    wait_issue("t5_issue_timeout");
    for (int i = 0; i < TO + 10; i++) tick();
`ifdef ELEV_REQ_TIMEOUT_EN
    chk("t5_stall", {31'd0, stall}, 32'd1);
    chk("t5_rv_dropped", {31'd0, req_valid}, 32'd0);
`else
    chk("t5_stall", {31'd0, stall}, 32'd0);
    chk("t5_rv_held", {31'd0, req_valid}, 32'd1);
`endif
    chk("t5_pending_kept", {24'd0, pending}, 32'h08);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
